// File: rtl/moore_seq_checker.sv
// Receive-side monitor for a 2-bit modulo-4 up-counting state stream: acquires lock,
// flags broken transitions while locked and keeps saturating error/good counters.
module moore_seq_checker #(
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       in_state,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] good_count
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } st_t;

    localparam logic [3:0]       LOCK_LEN_C = 4'(LOCK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};

    st_t              st_r;
    logic [1:0]       prev_r;
    logic [3:0]       run_r;
    logic             locked_r;
    logic             err_pulse_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] good_count_r;

    logic [1:0]       exp_s;
    logic [3:0]       run_inc_s;
    logic             match_s;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX_C) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Expected next code wraps naturally in two bits (11 -> 00 is legal).
    always_comb begin
        exp_s     = prev_r + 2'd1;
        run_inc_s = run_r + 4'd1;
        match_s   = (in_state == exp_s);
    end

    // Checker state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_r         <= ST_UNLOCKED;
            prev_r       <= 2'd0;
            run_r        <= 4'd0;
            locked_r     <= 1'b0;
            err_pulse_r  <= 1'b0;
            err_count_r  <= {CNT_W{1'b0}};
            good_count_r <= {CNT_W{1'b0}};
        end else begin
            err_pulse_r <= 1'b0;
            if (in_valid) begin
                prev_r <= in_state;
                case (st_r)
                    ST_UNLOCKED: begin
                        run_r    <= 4'd0;
                        st_r     <= ST_ACQUIRE;
                        locked_r <= 1'b0;
                    end
                    ST_ACQUIRE: begin
                        if (match_s) begin
                            run_r <= run_inc_s;
                            if (run_inc_s == LOCK_LEN_C) begin
                                st_r     <= ST_LOCKED;
                                locked_r <= 1'b1;
                            end else begin
                                st_r     <= ST_ACQUIRE;
                                locked_r <= 1'b0;
                            end
                        end else begin
                            run_r    <= 4'd0;
                            st_r     <= ST_ACQUIRE;
                            locked_r <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        if (match_s) begin
                            good_count_r <= sat_inc(good_count_r);
                            st_r         <= ST_LOCKED;
                            locked_r     <= 1'b1;
                        end else begin
                            // A stall (repeated code) is also a broken transition.
                            err_pulse_r <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                            run_r       <= 4'd0;
                            st_r        <= ST_ACQUIRE;
                            locked_r    <= 1'b0;
                        end
                    end
                    default: begin
                        run_r    <= 4'd0;
                        st_r     <= ST_UNLOCKED;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked     = locked_r;
    assign err_pulse  = err_pulse_r;
    assign err_count  = err_count_r;
    assign good_count = good_count_r;

endmodule

// File: doc/moore_seq_checker.md
# moore_seq_checker

Receive-side checker for the 2-bit Moore FSM state stream. It samples `in_state` on every clock where `in_valid` is high and acquires lock on the modulo-4 up-count sequence 00→01→10→11→00. Once locked, it flags every broken transition with a one-cycle error pulse and keeps saturating error and good-transition counters. It sits downstream of the FSM output bus as a self-contained protocol monitor that synthesises into the design.

## Interface
- `LOCK_LEN`, 3: consecutive correct transitions required to assert `locked`; legal range 1 to 15.
- `CNT_W`, 8: width of `err_count` and `good_count`.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `in_valid`  input  1  `in_state` is sampled on this edge.
- `in_state`  input  2  observed FSM state code.
- `locked`  output  1  checker is in the LOCKED state.
- `err_pulse`  output  1  one-cycle pulse for each broken transition while locked.
- `err_count`  output  CNT_W  saturating count of errors.
- `good_count`  output  CNT_W  saturating count of correct transitions seen while locked.

## Operation
- Internal registers:
  - `st` ∈ {UNLOCKED, ACQUIRE, LOCKED}.
  - `prev[1:0]`: last sampled code.
  - `run[3:0]`: count of consecutive correct transitions.
- `exp` = `prev` + 1, computed mod 4 (2-bit wrap, so 11→00 is correct).
- When `in_valid` = 0, all registers hold and `err_pulse` = 0.
- UNLOCKED, valid sample:
  - `prev` ← `in_state`, `run` ← 0.
  - Go to ACQUIRE.
- ACQUIRE, valid sample:
  - `prev` ← `in_state` on every sample.
  - If `in_state` == `exp`: `run` ← `run` + 1. If `run` + 1 == `LOCK_LEN`, go to LOCKED.
  - Otherwise: `run` ← 0 and stay in ACQUIRE. No error is reported while unlocked.
- LOCKED, valid sample:
  - `prev` ← `in_state` on every sample.
  - If `in_state` == `exp`: `good_count` increments, saturating at 2^CNT_W−1.
  - Otherwise:
    - `err_pulse` ← 1 and `err_count` increments (saturating).
    - `run` ← 0 and go to ACQUIRE.
  - A repeated code (stall, e.g. 01,01) counts as an error.
- `locked` = (`st` == LOCKED), registered.
- Counters clear only on `reset`. They never wrap.

## Timing
- All outputs are registered. Each reflects the sample taken on the previous rising edge, so latency is 1 clock.
- `err_pulse` is high for exactly one cycle per offending sample. Back-to-back errors cannot occur, because the first error exits LOCKED.
- `locked` rises on the edge that accepts the `LOCK_LEN`-th correct transition. It falls on the edge that accepts an erroneous sample, which is the same edge that raises `err_pulse`.
- Reset:
  - On the edge where `reset` = 1, `st` ← UNLOCKED, `prev` ← 00, `run` ← 0.
  - All outputs are 0 from the following cycle: `locked` = 0, `err_pulse` = 0, `err_count` = 0, `good_count` = 0.
  - `reset` has priority over `in_valid`. A sample presented during reset is discarded.
  - Reset mid-lock discards the lock and all counts. Reacquisition needs 1 + `LOCK_LEN` valid samples.
- Minimum time to lock from reset deassertion is 1 + `LOCK_LEN` valid cycles.

## Test plan
- Lock acquisition: reset for 2 cycles, then valid stream 00,01,10,11,00,01 (`LOCK_LEN` = 3).
  - `locked` = 0 through the 3rd sample and 1 after the 4th sample's edge.
  - `good_count` = 2 after the 6th sample.
  - `err_count` = 0.
- Error while locked: after lock on …10,11, present 10.
  - `err_pulse` = 1 for exactly one cycle, `err_count` = 1, `locked` = 0 on that same cycle.
  - Then 11,00,01 → `locked` = 1 again.
- Valid gaps: while locked, hold `in_valid` = 0 for 5 cycles with `in_state` toggling randomly, then resume the correct next code.
  - `locked` stays 1, `err_pulse` = 0, and counters are unchanged during the gap.
- Stall and wrap: while locked, send 11,00 → `good_count` increments (wrap is legal). Then send 00 again → `err_pulse`, and `err_count` increments.
- Saturation: with `CNT_W` = 4, force 20 lock/error cycles → `err_count` sticks at 15 and does not wrap.
- Reset mid-operation: while locked with `err_count` = 2, assert `reset` for 1 cycle alongside `in_valid` = 1.
  - The next cycle shows all outputs = 0.
  - Relock needs 4 correct valid samples.
